// File: rtl/r_reg.sv
`default_nettype none
// ============================================================================
//  Module      : r_reg
//  Description : Parameterizable D-type register chain with synchronous,
//                active-high reset. STAGES flops in series between d and q;
//                every stage loads RESET_VALUE on a reset edge. Optional
//                simulation-only X/Z check on d outside reset.
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps

module r_reg #(
   parameter int                 WIDTH       = 1,
   parameter int                 STAGES      = 1,
   parameter logic [WIDTH-1:0]   RESET_VALUE = {WIDTH{1'b0}},
   parameter int                 X_CHECK     = 0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   // Index of the stage that feeds q directly.
   localparam int c_LAST = STAGES - 1;

   // ------------------------------------------------------------------------
   // Elaboration-time parameter sanity. A zero width or zero depth has no
   // meaningful hardware interpretation, so stop immediately.
   // ------------------------------------------------------------------------
   generate
      if (WIDTH < 1) begin : g_bad_width
         $fatal(1, "r_reg: WIDTH must be 1 or greater (got %0d)", WIDTH);
      end
      if (STAGES < 1) begin : g_bad_stages
         $fatal(1, "r_reg: STAGES must be 1 or greater (got %0d)", STAGES);
      end
   endgenerate

   // The register chain; r_stage[0] samples d, r_stage[c_LAST] drives q.
   logic [WIDTH-1:0] r_stage [STAGES];

   generate
      // First stage: capture d each edge, reset has priority over data.
      always_ff @(posedge clk) begin
         if (reset) begin
            r_stage[0] <= RESET_VALUE;
         end else begin
            r_stage[0] <= d;
         end
      end

      for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
         // Subsequent stages shift the previous stage forward; reset clears
         // all in-flight data on the same edge.
         always_ff @(posedge clk) begin
            if (reset) begin
               r_stage[gi] <= RESET_VALUE;
            end else begin
               r_stage[gi] <= r_stage[gi-1];
            end
         end
      end
   endgenerate

   // q comes straight from the last flop with no logic after it.
   assign q = r_stage[c_LAST];

   // ------------------------------------------------------------------------
   // Simulation-only unknown-input watch. Unknowns still propagate through
   // the chain untouched; this only reports them, it never stops the run.
   // ------------------------------------------------------------------------
   generate
      if (X_CHECK == 1) begin : g_x_check
`ifndef SYNTHESIS
         // Report each non-reset edge that samples X/Z on d.
         always @(posedge clk) begin
            if (!reset && $isunknown(d)) begin
               $warning("r_reg: unknown value on d at time %0t: d=%b", $time, d);
            end
         end
`endif
      end
   endgenerate

endmodule

`default_nettype wire

// File: tb/tb_r_reg.sv
`default_nettype none
// ============================================================================
//  Module      : tb_r_reg
//  Description : Directed self-checking bench for r_reg. One default-shaped
//                instance (1 bit, 1 stage, X check on) and one pipelined
//                instance (8 bit, 3 stages, reset value 8'hA5).
//  Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps

module tb_r_reg;

   logic       clk;
   logic       reset;
   logic       d;
   logic       q;
   logic       rst8;
   logic [7:0] d8;
   logic [7:0] q8;

   int n_chk;
   int n_pass;

   r_reg #(
      .WIDTH       (1),
      .STAGES      (1),
      .RESET_VALUE (1'b0),
      .X_CHECK     (1)
   ) u_dut1 (
      .clk   (clk),
      .reset (reset),
      .d     (d),
      .q     (q)
   );

   r_reg #(
      .WIDTH       (8),
      .STAGES      (3),
      .RESET_VALUE (8'hA5),
      .X_CHECK     (0)
   ) u_dut8 (
      .clk   (clk),
      .reset (rst8),
      .d     (d8),
      .q     (q8)
   );

   // 2 ns clock, rising edges at 1, 3, 5 ... ns.
   initial clk = 1'b0;
   always #1 clk = ~clk;

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %b expected %b", tag, obs, exp);
   endtask

   task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
   endtask

   initial begin
      logic pat [8];
      logic exp_q;

      n_chk  = 0;
      n_pass = 0;
      pat[0] = 1'b0; pat[1] = 1'b0; pat[2] = 1'b1; pat[3] = 1'b1;
      pat[4] = 1'b0; pat[5] = 1'b0; pat[6] = 1'bx; pat[7] = 1'bx;

      reset = 1'b1;
      d     = 1'b0;
      rst8  = 1'b1;
      d8    = 8'h00;

      // Reset hold: q is 0 after the first edge and stays there.
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk1("reset_hold", q, 1'b0);
         chk8("pipe_reset_hold", q8, 8'hA5);
      end

      // Repeating pattern, driven on falling edges; STAGES=1 so q follows
      // the value sampled at the preceding rising edge.
      reset = 1'b0;
      for (int k = 0; k < 80; k++) begin
         d     = pat[k % 8];
         exp_q = pat[k % 8];
         @(negedge clk);
         chk1("pattern", q, exp_q);
      end

      // X propagation then recovery to 0.
      d = 1'bx;
      @(negedge clk);
      chk1("x_prop_1", q, 1'bx);
      @(negedge clk);
      chk1("x_prop_2", q, 1'bx);
      d = 1'b0;
      @(negedge clk);
      chk1("x_recover", q, 1'b0);

      // Mid-stream reset pulse for one cycle.
      d = 1'b1;
      @(negedge clk);
      chk1("pre_reset_q1", q, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      chk1("mid_reset", q, 1'b0);
      reset = 1'b0;
      @(negedge clk);
      chk1("post_reset_q1", q, 1'b1);

      // Reset pulse entirely between rising edges must not affect q.
      d = 1'b1;
      #0.2 reset = 1'b1;
      #0.4 reset = 1'b0;
      @(negedge clk);
      chk1("between_edge_reset", q, 1'b1);
      // Data change after the rising edge is invisible until the next one.
      @(posedge clk);
      #0.3 d = 1'b0;
      #0.3 chk1("d_between_edges", q, 1'b1);
      @(negedge clk);
      @(negedge clk);
      chk1("d_between_edges_next", q, 1'b0);

      // Pipeline: release reset with 8'h3C for one cycle, then 8'h00.
      rst8 = 1'b0;
      d8   = 8'h3C;
      @(negedge clk);            // edge E1 sampled 3C
      chk8("pipe_e1", q8, 8'hA5);
      d8 = 8'h00;
      @(negedge clk);            // E2
      chk8("pipe_e2", q8, 8'hA5);
      @(negedge clk);            // E3: 3C reaches q
      chk8("pipe_e3", q8, 8'h3C);
      @(negedge clk);            // E4: only one cycle
      chk8("pipe_e4", q8, 8'h00);
      // Mid-stream reset on the pipeline discards in-flight data.
      d8 = 8'h77;
      @(negedge clk);
      d8 = 8'h11;
      rst8 = 1'b1;
      @(negedge clk);
      chk8("pipe_mid_reset", q8, 8'hA5);
      rst8 = 1'b0;
      d8   = 8'h00;
      @(negedge clk);
      chk8("pipe_flushed_1", q8, 8'hA5);
      @(negedge clk);
      chk8("pipe_flushed_2", q8, 8'hA5);
      @(negedge clk);
      chk8("pipe_flushed_3", q8, 8'h00);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

`default_nettype wire
